// File: rtl/prefix_sum_stage.sv
// Final stage of the parallel-prefix adder.
// Takes the per-group carries from the prefix tree plus delay-matched bit
// generate/propagate. It ripples carries inside each group and forms the sum
// and flags. The result is registered behind a valid/ready handshake with a
// one-entry skid buffer, so back-pressure never drops a beat.
module prefix_sum_stage #(
    parameter int INPUTSIZE = 64,
    parameter int GROUPSIZE = 4,
    parameter int TAG_W     = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [2*(INPUTSIZE/GROUPSIZE)-1:0]    in_gq,
    input  logic [INPUTSIZE-1:0]                  in_g,
    input  logic [INPUTSIZE-1:0]                  in_p,
    input  logic                                  in_cin,
    input  logic [TAG_W-1:0]                      in_tag,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [INPUTSIZE-1:0]                  out_sum,
    output logic                                  out_cout,
    output logic                                  out_ovf,
    output logic                                  out_zero,
    output logic [TAG_W-1:0]                      out_tag
);

    localparam int NGRP = INPUTSIZE / GROUPSIZE;

    // Occupancy: bit0 = output register full, bit1 = skid register full.
    // Skid-only (2'b10) is unreachable.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    typedef struct packed {
        logic [INPUTSIZE-1:0] sum;
        logic                 cout;
        logic                 ovf;
        logic                 zero;
        logic [TAG_W-1:0]     tag;
    } beat_t;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic                 or_full;
    logic                 sk_full;
    logic                 accept;
    logic                 or_open;
    logic                 or_load_new;
    logic                 or_load_sk;
    logic                 sk_load;

    logic [NGRP-1:0]      gq_g;
    logic [NGRP-1:0]      gq_p;
    logic [NGRP-1:0]      cg;
    logic [NGRP-1:0]      grp_cout;
    logic [INPUTSIZE-1:0] bit_cin;
    logic [INPUTSIZE-1:0] sum_w;
    logic                 grp_ok;
    logic                 unused_gq_p;

    beat_t                new_beat;
    beat_t                or_beat;
    beat_t                sk_beat;

    // Split the tree output into per-group generate and propagate vectors.
    always_comb begin
        gq_g = '0;
        gq_p = '0;
        for (int k = 0; k < NGRP; k++) begin
            gq_g[k] = in_gq[2*k+1];
            gq_p[k] = in_gq[2*k];
        end
    end

    // Group propagate is only needed inside the tree; it is already
    // folded into the group carries here.
    assign unused_gq_p = ^gq_p;

    // Group k's carry-in is the tree carry out of group k-1. Group 0 uses cin.
    assign cg = {gq_g[NGRP-2:0], in_cin};

    // Ripple carries bit by bit inside each group, starting from that
    // group's tree carry.
    always_comb begin
        logic cc;
        cc       = 1'b0;
        bit_cin  = '0;
        grp_cout = '0;
        for (int k = 0; k < NGRP; k++) begin
            cc = cg[k];
            for (int j = 0; j < GROUPSIZE; j++) begin
                bit_cin[k*GROUPSIZE+j] = cc;
                cc = in_g[k*GROUPSIZE+j] | (in_p[k*GROUPSIZE+j] & cc);
            end
            grp_cout[k] = cc;
        end
    end

    assign sum_w  = in_p ^ bit_cin;
    assign grp_ok = (grp_cout == gq_g);

    // The rippled group carry-out must agree with the tree's group carry.
    grp_carry_chk: assert property (@(posedge clk) disable iff (!rst_n)
                                    in_valid |-> grp_ok);

    // Build the result beat. Its flags come from the same operands as its sum.
    always_comb begin
        new_beat      = '0;
        new_beat.sum  = sum_w;
        new_beat.cout = in_gq[2*NGRP-1];
        new_beat.ovf  = grp_cout[NGRP-1] ^ bit_cin[INPUTSIZE-1];
        new_beat.zero = ~|sum_w;
        new_beat.tag  = in_tag;
    end

    assign or_full  = state[0];
    assign sk_full  = state[1];
    assign in_ready = ~sk_full;
    assign accept   = in_valid & in_ready;
    assign or_open  = ~or_full | out_ready;

    // The skid entry has priority for the output register. A new beat cannot
    // be accepted in the same cycle, because in_ready is low while the skid is full.
    assign or_load_sk  = or_open & sk_full;
    assign or_load_new = or_open & ~sk_full & accept;
    assign sk_load     = ~or_open & accept;

    // Next occupancy from accept and drain events.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: state_nxt = accept ? ST_ONE : ST_EMPTY;
            ST_ONE: begin
                if (out_ready) state_nxt = accept ? ST_ONE  : ST_EMPTY;
                else           state_nxt = accept ? ST_FULL : ST_ONE;
            end
            ST_FULL:  state_nxt = out_ready ? ST_ONE : ST_FULL;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // ---- stage boundary: occupancy register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    // ---- stage boundary: output register (cleared so reset outputs read zero) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           or_beat <= '0;
        else if (or_load_sk)  or_beat <= sk_beat;
        else if (or_load_new) or_beat <= new_beat;
    end

    // ---- stage boundary: skid register (payload only, qualified by state) ----
    always_ff @(posedge clk) begin
        if (sk_load) sk_beat <= new_beat;
    end

    assign out_valid = or_full;
    assign out_sum   = or_beat.sum;
    assign out_cout  = or_beat.cout;
    assign out_ovf   = or_beat.ovf;
    assign out_zero  = or_beat.zero;
    assign out_tag   = or_beat.tag;

endmodule

// File: tb/tb_prefix_sum_stage.sv
// Bench for prefix_sum_stage.
// Operands are converted into tree-style inputs (bit g/p, group carries).
// Expected results come from integer addition and go onto a scoreboard queue.
// They are compared whenever the stage hands a beat downstream.
module tb_prefix_sum_stage;

    localparam int INPUTSIZE = 64;
    localparam int GROUPSIZE = 4;
    localparam int TAG_W     = 4;
    localparam int NGRP      = INPUTSIZE / GROUPSIZE;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [3:0]  tag;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [2*NGRP-1:0]     in_gq;
    logic [INPUTSIZE-1:0]  in_g;
    logic [INPUTSIZE-1:0]  in_p;
    logic                  in_cin;
    logic [TAG_W-1:0]      in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [INPUTSIZE-1:0]  out_sum;
    logic                  out_cout;
    logic                  out_ovf;
    logic                  out_zero;
    logic [TAG_W-1:0]      out_tag;

    int   errors = 0;
    int   checks = 0;
    int   n_out  = 0;
    bit   rnd_ready = 1'b0;
    exp_t sb[$];

    prefix_sum_stage #(.INPUTSIZE(INPUTSIZE), .GROUPSIZE(GROUPSIZE), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_gq(in_gq), .in_g(in_g), .in_p(in_p), .in_cin(in_cin), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Golden result from plain wide addition.
    function automatic exp_t golden(logic [63:0] a, logic [63:0] b, logic cin, logic [3:0] tag);
        exp_t        e;
        logic [64:0] s;
        s      = {1'b0, a} + {1'b0, b} + 65'(cin);
        e.sum  = s[63:0];
        e.cout = s[64];
        e.ovf  = (a[63] == b[63]) && (s[63] != a[63]);
        e.zero = (s[63:0] == 64'd0);
        e.tag  = tag;
        return e;
    endfunction

    // Tree output: G = carry out of bits [w-1:0] incl. cin, P = AND of group p.
    function automatic logic [2*NGRP-1:0] mk_gq(logic [63:0] a, logic [63:0] b, logic cin);
        logic [2*NGRP-1:0] r;
        logic [64:0]       m;
        logic [64:0]       s;
        logic [63:0]       p;
        int                w;
        r = '0;
        p = a ^ b;
        for (int k = 0; k < NGRP; k++) begin
            w = (k + 1) * GROUPSIZE;
            m = (65'd1 << w) - 65'd1;
            s = ({1'b0, a} & m) + ({1'b0, b} & m) + 65'(cin);
            r[2*k+1] = s[w];
            r[2*k]   = &p[k*GROUPSIZE +: GROUPSIZE];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Present one beat and hold it until accepted. Returns at posedge+1 of
    // the accepting edge, with in_valid still high.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin,
                        input logic [3:0] tag, input exp_t e);
        int t;
        in_g     = a & b;
        in_p     = a ^ b;
        in_cin   = cin;
        in_gq    = mk_gq(a, b, cin);
        in_tag   = tag;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tag %0d not accepted, required acceptance within 200 cycles", tag);
            in_valid = 1'b0;
        end else begin
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        check(name, 64'(sb.size()), 64'd0);
    endtask

    // Random downstream back-pressure, when enabled.
    always @(posedge clk) begin
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard compare on every downstream transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t got;
            exp_t e;
            got = '{sum: out_sum, cout: out_cout, ovf: out_ovf, zero: out_zero, tag: out_tag};
            checks++;
            n_out++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got tag %0d sum %h, required no output", out_tag, out_sum);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL beat: got sum=%h cout=%b ovf=%b zero=%b tag=%0d, required sum=%h cout=%b ovf=%b zero=%b tag=%0d",
                             got.sum, got.cout, got.ovf, got.zero, got.tag,
                             e.sum, e.cout, e.ovf, e.zero, e.tag);
                end
            end
        end
    end

    initial begin
        vec_t        vecs[6];
        exp_t        e;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        int          n0;
        int          pulses;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 4'd1, 64'd0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 4'd2, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{64'd0, 64'd0, 1'b1, 4'd3, 64'd1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 4'd4, 64'd0, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 4'd5, 64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_g      = '0;
        in_p      = '0;
        in_gq     = '0;
        in_cin    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_sum",   out_sum,        64'd0);
        check("rst_out_tag",   64'(out_tag),   64'd0);

        // Directed vectors: one-cycle latency, then a scoreboard compare on drain.
        for (int i = 0; i < 6; i++) begin
            e = '{sum: vecs[i].sum, cout: vecs[i].cout, ovf: vecs[i].ovf,
                  zero: vecs[i].zero, tag: vecs[i].tag};
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].tag, e);
            check($sformatf("latency_valid_%0d", i), 64'(out_valid), 64'd1);
            check($sformatf("latency_sum_%0d", i), out_sum, vecs[i].sum);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        wait_drain("vec_drain");

        // Skid: tag0 in the output register, tag1 in the skid register, then back-pressure.
        out_ready = 1'b0;
        n0 = n_out;
        for (int t = 0; t < 2; t++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            cin = 1'(t);
            send(a, b, cin, 4'(t), golden(a, b, cin, 4'(t)));
        end
        check("skid_in_ready", 64'(in_ready),  64'd0);
        check("skid_or_tag",   64'(out_tag),   64'd0);
        check("skid_or_valid", 64'(out_valid), 64'd1);
        fork
            begin
                for (int t = 2; t < 8; t++) begin
                    logic [63:0] sa;
                    logic [63:0] sb_;
                    sa  = {$urandom, $urandom};
                    sb_ = {$urandom, $urandom};
                    send(sa, sb_, 1'b0, 4'(t), golden(sa, sb_, 1'b0, 4'(t)));
                end
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain("skid_drain");
        check("skid_count", 64'(n_out - n0), 64'd8);

        // Reset with both registers occupied: everything in flight is discarded.
        out_ready = 1'b0;
        for (int t = 0; t < 2; t++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            send(a, b, 1'b0, 4'(8 + t), golden(a, b, 1'b0, 4'(8 + t)));
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_sum",   out_sum,        64'd0);
        sb.delete();
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        pulses = 0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("midrst_no_pulse", 64'(pulses), 64'd0);
        @(posedge clk);
        #1;

        // Random operands with random gaps and random back-pressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            cin = 1'($urandom_range(0, 1));
            if (i % 16 == 0) b = ~a;
            send(a, b, cin, 4'(i), golden(a, b, cin, 4'(i)));
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
        in_valid  = 1'b0;
        rnd_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_drain("rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
